// File: rtl/comparador_serial_pkg.sv
// rtl/comparador_serial_pkg.sv - shared encodings and cell rule for the bit-serial comparator
// Purpose: {p,q} state encodings, FSM state type and a behavioural cell-rule helper.
// Ports: none (package).
package comparador_pkg;

    localparam logic [1:0] PQ_EQ = 2'b01;
    localparam logic [1:0] PQ_GT = 2'b10;
    localparam logic [1:0] PQ_LT = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // One step of the comparator cell: GT and LT absorb, EQ resolves on the first differing bit.
    function automatic logic [1:0] pq_cell(input logic [1:0] pq, input logic ai, input logic bi);
        if (pq != PQ_EQ) return pq;
        if (ai && !bi)   return PQ_GT;
        if (!ai && bi)   return PQ_LT;
        return PQ_EQ;
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// rtl/comparador_serial_if.sv - operand and verdict handshakes of the bit-serial comparator
// Purpose: groups the input pair handshake and the verdict handshake.
// Ports: in_valid/in_ready/in_a/in_b (operand pair), out_valid/out_ready/out_gt/out_lt/out_eq/out_p/out_q (verdict).
interface comparador_serial_if #(
    parameter int N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic         out_gt;
    logic         out_lt;
    logic         out_eq;
    logic         out_p;
    logic         out_q;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gt, out_lt, out_eq, out_p, out_q
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gt, out_lt, out_eq, out_p, out_q
    );
endinterface

// File: rtl/comparador_serial_celda.sv
// rtl/comparador_serial_celda.sv - typical comparator cell, combinational
// Purpose: advances the running {p,q} comparison state by one bit pair.
// Ports: p,q (current state), Ai,Bi (operand bits), P,Q (next state).
module celdaTipica (
    input  logic p,
    input  logic q,
    input  logic Ai,
    input  logic Bi,
    output logic P,
    output logic Q
);
    // GT (10) holds P; from EQ (01) P rises only when A's bit wins.
    assign P = (p & ~q) | (~p & q & Ai & ~Bi);
    // Q stays high only while still EQ and the bits match; GT and LT both have Q=0.
    assign Q = ~p & q & ~(Ai ^ Bi);
endmodule

// File: rtl/comparador_serial.sv
// rtl/comparador_serial.sv - bit-serial MSB-first magnitude comparator with valid/ready handshakes
// Purpose: accepts an (A,B) pair, walks it through one comparator cell per clock,
//          then holds a GT/LT/EQ verdict plus final {P,Q} until the consumer takes it.
// Ports: clk, rst_n (async active-low), bus (comparador_serial_if.slave), busy (SHIFT or HOLD).
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int N          = 3,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    comparador_serial_if.slave     bus,
    output logic                   busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q;
    logic [1:0]    pq_q;
    logic [1:0]    pq_d;
    logic [N-1:0]  sa_q;
    logic [N-1:0]  sb_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic          out_gt_q;
    logic          out_lt_q;
    logic          out_eq_q;
    logic          out_p_q;
    logic          out_q_q;
    logic          finish;

    celdaTipica u_celda (
        .p  (pq_q[1]),
        .q  (pq_q[0]),
        .Ai (sa_q[N-1]),
        .Bi (sb_q[N-1]),
        .P  (pq_d[1]),
        .Q  (pq_d[0])
    );

    // Last bit processed, or (early exit) the verdict is already decided.
    assign finish = (cnt_q == '0) || (EARLY_EXIT && (pq_d != PQ_EQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pq_q        <= PQ_EQ;
            sa_q        <= '0;
            sb_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_gt_q    <= 1'b0;
            out_lt_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_p_q     <= 1'b0;
            out_q_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sa_q    <= bus.in_a;
                        sb_q    <= bus.in_b;
                        pq_q    <= PQ_EQ;
                        cnt_q   <= CW'(N - 1);
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    pq_q <= pq_d;
                    sa_q <= {sa_q[N-2:0], 1'b0};
                    sb_q <= {sb_q[N-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    if (finish) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        out_gt_q    <= (pq_d == PQ_GT);
                        out_lt_q    <= (pq_d == PQ_LT);
                        out_eq_q    <= (pq_d == PQ_EQ);
                        out_p_q     <= pq_d[1];
                        out_q_q     <= pq_d[0];
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_gt    = out_gt_q;
    assign bus.out_lt    = out_lt_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_q     = out_q_q;

endmodule
